// File: rtl/adc_sample_fifo.sv
// rtl/adc_sample_fifo.sv - ADC word capture: offset-binary to left-aligned two's complement,
// buffered in a first-word-fall-through FIFO with drop flag and saturating drop counter.
module adc_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int OUT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             en,
  output logic             adc_rx_en,
  input  logic             adc_done_tick,
  input  logic [11:0]      adc_din,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [AW:0]      level,
  output logic             full,
  output logic             overflow,
  output logic [7:0]       ovf_cnt,
  input  logic             clr_ovf
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;
  logic             push_req, push, pop, drop;
  logic [OUT_W-1:0] word;

  assign full      = (level_q == FULL_LVL);
  assign m_valid   = (level_q != '0);
  assign adc_rx_en = en & ~full;
  assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign ovf_cnt   = ovf_cnt_q;

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push_req = adc_done_tick & en;
  assign pop      = m_valid & m_ready;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    word = '0;
    word[OUT_W-1 -: 12] = {~adc_din[11], adc_din[10:0]};
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    // Clearing wins over a drop landing on the same edge.
    if (clr_ovf) begin
      ovf_d     = 1'b0;
      ovf_cnt_d = 8'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  always_ff @(posedge sclk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// tb/tb_adc_sample_fifo.sv - directed vectors and queue scoreboard for adc_sample_fifo.
module tb_adc_sample_fifo;

  localparam int DEPTH = 8;

  logic        sclk = 1'b0;
  logic        rst, en, adc_done_tick, m_ready, clr_ovf;
  logic [11:0] adc_din;
  logic        adc_rx_en, m_valid, full, overflow;
  logic [15:0] m_data;
  logic [3:0]  level;
  logic [7:0]  ovf_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mq[$];
  logic        movf;
  int          mcnt;

  typedef struct {
    logic [11:0] din;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[6];

  adc_sample_fifo #(.DEPTH(DEPTH), .OUT_W(16)) dut (
    .sclk(sclk), .rst(rst), .en(en), .adc_rx_en(adc_rx_en),
    .adc_done_tick(adc_done_tick), .adc_din(adc_din),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .full(full), .overflow(overflow),
    .ovf_cnt(ovf_cnt), .clr_ovf(clr_ovf)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] conv(input logic [11:0] d);
    return {d ^ 12'h800, 4'h0};
  endfunction

  // One clock: drive at a negedge, update the model, compare at the following negedge.
  task automatic step(input logic tk, input logic [11:0] d, input logic rdy, input logic clr,
                      input string nm);
    logic pop, preq, acc, drp, fl;
    adc_done_tick = tk;
    adc_din       = d;
    m_ready       = rdy;
    clr_ovf       = clr;
    fl   = (mq.size() == DEPTH);
    pop  = (mq.size() > 0) && rdy;
    preq = tk && en;
    acc  = preq && (!fl || pop);
    drp  = preq && fl && !pop;
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(conv(d));
    if (clr) begin
      movf = 1'b0;
      mcnt = 0;
    end else if (drp) begin
      movf = 1'b1;
      if (mcnt < 255) mcnt++;
    end
    @(negedge sclk);
    adc_done_tick = 1'b0;
    m_ready       = 1'b0;
    clr_ovf       = 1'b0;
    chk({nm, ".level"},    level,    mq.size());
    chk({nm, ".m_valid"},  m_valid,  mq.size() > 0);
    chk({nm, ".m_data"},   m_data,   (mq.size() > 0) ? mq[0] : 16'h0000);
    chk({nm, ".full"},     full,     mq.size() == DEPTH);
    chk({nm, ".rx_en"},    adc_rx_en, en && (mq.size() != DEPTH));
    chk({nm, ".overflow"}, overflow, movf);
    chk({nm, ".ovf_cnt"},  ovf_cnt,  mcnt);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{12'h000, 16'h8000};
    vecs[1] = '{12'h800, 16'h0000};
    vecs[2] = '{12'hFFF, 16'h7FF0};
    vecs[3] = '{12'h7FF, 16'hFFF0};
    vecs[4] = '{12'h123, 16'h9230};
    vecs[5] = '{12'hA5C, 16'h25C0};

    rst = 1'b1; en = 1'b0; adc_done_tick = 1'b0; adc_din = '0; m_ready = 1'b0; clr_ovf = 1'b0;
    movf = 1'b0; mcnt = 0;

    @(negedge sclk);
    chk("rst.level",    level,    0);
    chk("rst.m_valid",  m_valid,  0);
    chk("rst.m_data",   m_data,   0);
    chk("rst.full",     full,     0);
    chk("rst.overflow", overflow, 0);
    chk("rst.ovf_cnt",  ovf_cnt,  0);
    chk("rst.rx_en0",   adc_rx_en, 0);
    en = 1'b1;
    #1;
    chk("rst.rx_en1",   adc_rx_en, 1);
    @(negedge sclk);
    rst = 1'b0;

    // Conversion table: capture all, then pop in order.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, vecs[i].din, 1'b0, 1'b0, "conv_push");
      if (i == 0) chk("latency.m_valid", m_valid, 1);
      if (i == 3) chk("conv.level4", level, 4);
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("conv.vec%0d", i), m_data, vecs[i].exp);
      step(1'b0, 12'h000, 1'b1, 1'b0, "conv_pop");
    end
    chk("conv.empty_data", m_data, 0);
    step(1'b0, 12'h000, 1'b1, 1'b0, "pop_empty");

    // Fill, drop, clear, clear-versus-drop, full push+pop.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 12'(i * 273 + 10), 1'b0, 1'b0, "fill");
    chk("fill.level8", level, 8);
    chk("fill.rx_en",  adc_rx_en, 0);
    step(1'b1, 12'hABC, 1'b0, 1'b0, "drop1");
    chk("drop1.ovf_cnt",  ovf_cnt, 1);
    chk("drop1.head",     m_data, 16'h80A0);
    step(1'b0, 12'h000, 1'b0, 1'b1, "clr");
    step(1'b1, 12'h555, 1'b0, 1'b0, "drop2");
    step(1'b1, 12'h555, 1'b0, 1'b1, "clr_vs_drop");
    chk("clr_vs_drop.cnt", ovf_cnt, 0);
    step(1'b1, 12'h3C3, 1'b1, 1'b0, "full_pushpop");
    chk("full_pushpop.level", level, 8);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 12'h000, 1'b1, 1'b0, "drain");
    chk("drain.empty", m_valid, 0);

    // Continuous stream, one tick every 17 cycles.
    for (int t = 0; t < 5; t++) begin
      step(1'b1, 12'(t * 701 + 3), 1'b1, 1'b0, "stream_tick");
      chk("stream.valid", m_valid, 1);
      for (int c = 0; c < 16; c++) begin
        step(1'b0, 12'h000, 1'b1, 1'b0, "stream_idle");
        chk("stream.level_le1", level <= 1, 1);
      end
    end

    // Saturating drop counter.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 12'(i * 91), 1'b0, 1'b0, "fill2");
    for (int i = 0; i < 300; i++) step(1'b1, 12'hF0F, 1'b0, 1'b0, "sat");
    chk("sat.ovf_cnt", ovf_cnt, 255);
    step(1'b0, 12'h000, 1'b0, 1'b1, "sat_clr");

    // Pointer wrap with sustained push+pop at level 3.
    for (int i = 0; i < 5; i++) step(1'b0, 12'h000, 1'b1, 1'b0, "to3");
    for (int i = 0; i < 20; i++) step(1'b1, 12'(i * 37 + 2048), 1'b1, 1'b0, "wrap");
    chk("wrap.level3", level, 3);

    // en dropped: stored samples still drain, new ticks ignored.
    en = 1'b0;
    step(1'b1, 12'h111, 1'b1, 1'b0, "en_off_pop");
    step(1'b0, 12'h000, 1'b1, 1'b0, "en_off_pop");
    step(1'b0, 12'h000, 1'b1, 1'b0, "en_off_pop");
    chk("en_off.empty", m_valid, 0);
    en = 1'b1;

    // Asynchronous reset with level 5.
    for (int i = 0; i < 5; i++) step(1'b1, 12'(i + 100), 1'b0, 1'b0, "pre_rst");
    chk("pre_rst.level5", level, 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.m_valid", m_valid, 0);
    chk("async_rst.level",   level,   0);
    chk("async_rst.m_data",  m_data,  0);
    mq.delete();
    movf = 1'b0;
    mcnt = 0;
    @(negedge sclk);
    rst = 1'b0;
    en  = 1'b0;
    step(1'b1, 12'h456, 1'b0, 1'b0, "tick_en0");
    chk("tick_en0.level", level, 0);
    en = 1'b1;
    step(1'b1, 12'h456, 1'b0, 1'b0, "resume");
    chk("resume.data", m_data, 16'hC560);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
